pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised, elastic pipeline-stage register for the RISC-V core's inter-stage boundaries (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces fixed per-stage registers with a single generic block. It adds a valid/ready handshake, an optional two-entry skid buffer, flush, and bubble semantics.
- Bubble semantics: a defined value is forced onto the kill field, for example reg_addr = 0 and mem_write = 0.
- Instantiated once per boundary, with the data bus being the concatenation of that stage's fields.

Parameters:
- DATA_W, 64: width of the pass-through payload; contents are don't-care when invalid.
- KILL_W, 6: width of the side-effect control field that is forced to KILL_VAL whenever the stage holds a bubble.
- KILL_VAL, 0: bubble value of the kill field. Width KILL_W; for example {reg_addr = 5'b0, mem_write = 1'b0}.
- SKID, 1: 1 selects a two-entry buffer with registered in_ready; 0 selects a single entry with combinational in_ready.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage accepts this cycle
- in_data  in  DATA_W  payload
- in_kill  in  KILL_W  side-effect control field
- flush  in  1  discard all held entries (branch/jalr redirect)
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head payload
- out_kill  out  KILL_W  head kill field; equals KILL_VAL when out_valid = 0
- occupancy  out  2  entries held (0..2; max 1 when SKID = 0)

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready at the rising edge.
  - Output transfer occurs when out_valid & out_ready at the rising edge.
- Reset: when rst = 1 at an edge, the block resets as follows.
  - Occupancy becomes 0, out_valid = 0 and out_kill = KILL_VAL.
  - out_data becomes 0.
  - in_ready = 1 from the cycle after reset; it is 0 while rst is asserted.
  - rst overrides every other input, including in the middle of a transfer.
- Storage, SKID = 1:
  - Two registers: head, which drives the outputs, and skid.
  - Entries are FIFO-ordered; head is always the oldest entry.
  - in_ready is a register output equal to !(skid occupied) from the previous edge. There is no combinational path from out_ready to in_ready.
  - Full throughput of one transfer per cycle is sustained with out_ready = 1.
  - State transitions per edge:
    - EMPTY + in: go to ONE.
    - ONE + in + out: stay in ONE, with head = new data.
    - ONE + in only: go to TWO, with skid = new data.
    - ONE + out only: go to EMPTY.
    - TWO + out: go to ONE, with head = skid.
    - TWO without out: hold TWO.
  - in_ready = 0 in TWO, so no input transfer can occur there.
- Storage, SKID = 0:
  - One entry.
  - in_ready = !out_valid | out_ready (combinational).
  - Accept and release in the same cycle is allowed.
- Flush:
  - Occupancy becomes 0 at the edge; out_valid = 0 on the next cycle.
  - Flush takes priority over a simultaneous input transfer: the input is dropped, even though upstream saw in_ready = 1.
  - A simultaneous output transfer still counts as completed for downstream.
- Bubble:
  - Whenever out_valid = 0, out_kill = KILL_VAL, applied combinationally from the valid bit.
  - out_data holds its last value while invalid; it is not cleared.
- Latency: one cycle from input transfer to out_valid when the block is empty.
- Data integrity:
  - No reordering, no duplication.
  - No entry is lost, except by flush or rst.
  - While out_valid = 1 & out_ready = 0, out_data and out_kill stay stable.
- occupancy is registered and equals the number of valid entries.

Test Plan:
- Reset and idle: assert rst for 2 cycles with in_valid = 1 → out_valid = 0, out_kill = 0, occupancy = 0 throughout. in_ready = 1 on the first cycle after rst deasserts.
- Streaming: SKID = 1, out_ready = 1, feed in_data = 1, 2, 3, 4 on consecutive cycles → out_data = 1, 2, 3, 4 on consecutive cycles, each one cycle after acceptance, with in_ready constantly 1.
- Backpressure:
  - Set out_ready = 0 after data 5 is accepted, then offer 6 and 7.
  - Required: occupancy = 2, in_ready = 0, and 7 is held upstream.
  - Set out_ready = 1: out_data = 5, then 6, then 7 (after 7 is accepted); no loss.
- Flush with collision: occupancy = 2 (entries 8 and 9), assert flush together with in_valid = 1 and data 10 → the next cycle shows out_valid = 0, out_kill = KILL_VAL, occupancy = 0, and 10 never appears on the output.
- Bubble kill field: KILL_VAL = 6'b000000, push in_kill = 6'b111111, then drain with out_ready = 1 → out_kill = 6'b111111 while valid, then 6'b000000 the cycle out_valid falls.
- SKID = 0 variant: out_valid = 1 with out_ready = 0 → in_ready = 0 in the same cycle. Raise out_ready → in_ready = 1 combinationally, and a new entry replaces the head at the edge with occupancy staying at 1.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register with valid/ready handshake, optional
// two-entry skid buffer, flush, and bubble forcing of the kill field.
module pipe_stage_buf #(
  parameter int                  DATA_W   = 64,
  parameter int                  KILL_W   = 6,
  parameter logic [KILL_W-1:0]   KILL_VAL = '0,
  parameter bit                  SKID     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [KILL_W-1:0] in_kill,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [KILL_W-1:0] out_kill,
  output logic [1:0]        occupancy
);

  logic              head_valid;
  logic [DATA_W-1:0] head_data;
  logic [KILL_W-1:0] head_kill;
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [KILL_W-1:0] skid_kill;
  logic [1:0]        occ_q;
  logic              in_xfer;
  logic              out_xfer;

  // With the skid buffer, in_ready depends only on registered state, which
  // breaks the combinational out_ready -> in_ready path between stages.
  generate
    if (SKID) begin : g_skid
      assign in_ready = !rst && !skid_valid;
    end else begin : g_single
      assign in_ready = !rst && (!head_valid || out_ready);
    end
  endgenerate

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = head_valid && out_ready;
  assign out_valid = head_valid;
  assign out_data  = head_data;
  assign out_kill  = head_valid ? head_kill : KILL_VAL;
  assign occupancy = occ_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_valid <= 1'b0;
      head_data  <= '0;
      head_kill  <= KILL_VAL;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_kill  <= KILL_VAL;
      occ_q      <= 2'd0;
    end else if (flush) begin
      // Payload registers keep their contents; only the valid bits drop.
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      occ_q      <= 2'd0;
    end else if (out_xfer) begin
      if (skid_valid) begin
        head_data  <= skid_data;
        head_kill  <= skid_kill;
        skid_valid <= 1'b0;
        occ_q      <= 2'd1;
      end else if (in_xfer) begin
        head_data  <= in_data;
        head_kill  <= in_kill;
        occ_q      <= 2'd1;
      end else begin
        head_valid <= 1'b0;
        occ_q      <= 2'd0;
      end
    end else if (in_xfer) begin
      if (head_valid) begin
        if (SKID) begin
          skid_data  <= in_data;
          skid_kill  <= in_kill;
          skid_valid <= 1'b1;
          occ_q      <= 2'd2;
        end
      end else begin
        head_data  <= in_data;
        head_kill  <= in_kill;
        head_valid <= 1'b1;
        occ_q      <= 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: skid (SKID=1) and single-entry
// (SKID=0) instances share clock and reset.
module tb_pipe_stage_buf;

  localparam int DW = 16;
  localparam int KW = 6;

  logic clk = 1'b0;
  logic rst;

  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [KW-1:0] in_kill, out_kill;
  logic [1:0]    occupancy;

  logic          in_valid0, in_ready0, flush0, out_valid0, out_ready0;
  logic [DW-1:0] in_data0, out_data0;
  logic [KW-1:0] in_kill0, out_kill0;
  logic [1:0]    occupancy0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_buf #(.DATA_W(DW), .KILL_W(KW), .KILL_VAL(6'b000000), .SKID(1'b1)) dut_skid (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_kill(in_kill), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_kill(out_kill), .occupancy(occupancy)
  );

  pipe_stage_buf #(.DATA_W(DW), .KILL_W(KW), .KILL_VAL(6'b000000), .SKID(1'b0)) dut_single (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data0), .in_kill(in_kill0), .flush(flush0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .out_kill(out_kill0), .occupancy(occupancy0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h00AA; in_kill = 6'h3F;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_cmp++; if (out_kill !== 6'h00) begin n_err++; $display("FAIL reset_out_kill got %h want 00", out_kill); end
      n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
      n_cmp++; if (out_data !== 16'h0000) begin n_err++; $display("FAIL reset_out_data got %h want 0000", out_data); end
    end
    n_cmp++; if (occupancy0 !== 2'd0) begin n_err++; $display("FAIL reset_occupancy0 got %0d want 0", occupancy0); end
    in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready0 got %b want 1", in_ready0); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1; in_valid = 1'b1; in_kill = 6'h01;
    for (int v = 1; v <= 4; v++) begin
      in_data = DW'(v);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d] got %b want 1", v, in_ready); end
      step();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== DW'(v)) begin
        n_err++; $display("FAIL stream_out[%0d] got v=%b d=%h want v=1 d=%h", v, out_valid, out_data, DW'(v)); end
      n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stream_occ[%0d] got %0d want 1", v, occupancy); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_err++; $display("FAIL stream_drain got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 16'd5;
    step();
    n_cmp++; if (out_data !== 16'd5) begin n_err++; $display("FAIL bp_head5 got %h want 0005", out_data); end
    out_ready = 1'b0; in_data = 16'd6;
    step();
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ_full got %0d want 2", occupancy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
    in_data = 16'd7;
    step();
    n_cmp++; if (occupancy !== 2'd2 || out_data !== 16'd5 || out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_hold got occ=%0d d=%h v=%b want occ=2 d=0005 v=1", occupancy, out_data, out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_hold got %b want 0", in_ready); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_data !== 16'd6 || occupancy !== 2'd1) begin
      n_err++; $display("FAIL bp_pop6 got d=%h occ=%0d want d=0006 occ=1", out_data, occupancy); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_reopen got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_data !== 16'd7 || out_valid !== 1'b1 || occupancy !== 2'd1) begin
      n_err++; $display("FAIL bp_pop7 got d=%h v=%b occ=%0d want d=0007 v=1 occ=1", out_data, out_valid, occupancy); end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_err++; $display("FAIL bp_empty got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_kill = 6'h2A; in_data = 16'd8;
    step();
    in_data = 16'd9;
    step();
    n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL flush_pre_occ got %0d want 2", occupancy); end
    flush = 1'b1; in_data = 16'd10;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || out_kill !== 6'h00 || occupancy !== 2'd0) begin
      n_err++; $display("FAIL flush_full got v=%b k=%h occ=%0d want v=0 k=00 occ=0", out_valid, out_kill, occupancy); end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost[%0d] got v=%b d=%h want v=0", i, out_valid, out_data); end
    end
    // One entry held, in_ready high: flush must drop the offered input.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd11;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_one_in_ready got %b want 1", in_ready); end
    flush = 1'b1; in_data = 16'd12;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_err++; $display("FAIL flush_collide got v=%b occ=%0d want v=0 occ=0", out_valid, occupancy); end
    n_cmp++; if (out_data !== 16'd11) begin n_err++; $display("FAIL flush_data_held got %h want 000b", out_data); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped_input got v=%b want 0", out_valid); end
  endtask

  task automatic test_bubble();
    out_ready = 1'b0; in_valid = 1'b1; in_kill = 6'h3F; in_data = 16'h0021;
    step();
    in_valid = 1'b0; in_kill = 6'h00;
    n_cmp++; if (out_valid !== 1'b1 || out_kill !== 6'h3F) begin
      n_err++; $display("FAIL bubble_valid_kill got v=%b k=%h want v=1 k=3f", out_valid, out_kill); end
    step();
    n_cmp++; if (out_kill !== 6'h3F || out_data !== 16'h0021) begin
      n_err++; $display("FAIL bubble_stable got k=%h d=%h want k=3f d=0021", out_kill, out_data); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0 || out_kill !== 6'h00) begin
      n_err++; $display("FAIL bubble_forced got v=%b k=%h want v=0 k=00", out_valid, out_kill); end
    n_cmp++; if (out_data !== 16'h0021) begin n_err++; $display("FAIL bubble_data_held got %h want 0021", out_data); end
  endtask

  task automatic test_single_entry();
    in_valid0 = 1'b1; in_data0 = 16'h0031; in_kill0 = 6'h15; out_ready0 = 1'b0;
    #1;
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL s0_empty_ready got %b want 1", in_ready0); end
    step();
    n_cmp++; if (out_valid0 !== 1'b1 || out_data0 !== 16'h0031 || out_kill0 !== 6'h15) begin
      n_err++; $display("FAIL s0_head got v=%b d=%h k=%h want v=1 d=0031 k=15", out_valid0, out_data0, out_kill0); end
    n_cmp++; if (in_ready0 !== 1'b0) begin n_err++; $display("FAIL s0_stall_ready got %b want 0", in_ready0); end
    in_data0 = 16'h0032; in_kill0 = 6'h0C; out_ready0 = 1'b1;
    #1;
    n_cmp++; if (in_ready0 !== 1'b1) begin n_err++; $display("FAIL s0_comb_ready got %b want 1", in_ready0); end
    step();
    n_cmp++; if (out_data0 !== 16'h0032 || out_kill0 !== 6'h0C || occupancy0 !== 2'd1) begin
      n_err++; $display("FAIL s0_replace got d=%h k=%h occ=%0d want d=0032 k=0c occ=1", out_data0, out_kill0, occupancy0); end
    in_valid0 = 1'b0;
    step();
    n_cmp++; if (out_valid0 !== 1'b0 || out_kill0 !== 6'h00 || occupancy0 !== 2'd0) begin
      n_err++; $display("FAIL s0_drain got v=%b k=%h occ=%0d want v=0 k=00 occ=0", out_valid0, out_kill0, occupancy0); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_kill = '0; flush = 1'b0; out_ready = 1'b0;
    in_valid0 = 1'b0; in_data0 = '0; in_kill0 = '0; flush0 = 1'b0; out_ready0 = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_single_entry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
